// File: rtl/eq_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg
// Shared types and helpers for the eq_biquad_cascade equaliser engine.
//   - coef_idx_e : coefficient select encoding used on the load bus and by the
//                  MAC sequencer (b0, b1, b2, a1, a2).
//   - eq_state_e : controller FSM states.
//   - N_COEF     : coefficients per biquad band.
//   - coef_identity() : value of a pass-through coefficient (b0 = 1.0).
//   - round_sat()     : round-half-up, arithmetic shift and saturate helper,
//                       with input/output widths passed as arguments.
// No ports (package).
// -----------------------------------------------------------------------------
package eq_pkg;

    localparam int N_COEF = 5;
    // Working width for round_sat; accumulators up to RS_W-1 bits are supported.
    localparam int RS_W   = 128;

    typedef enum logic [2:0] {
        COEF_B0 = 3'd0,
        COEF_B1 = 3'd1,
        COEF_B2 = 3'd2,
        COEF_A1 = 3'd3,
        COEF_A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_OUT  = 2'd3
    } eq_state_e;

    // Identity biquad: b0 = 1.0 in the coefficient fixed-point format.
    function automatic logic signed [63:0] coef_identity(input int idx, input int frac);
        logic signed [63:0] c;
        c = '0;
        if (idx == 0) begin
            c = 64'sd1 <<< frac;
        end
        return c;
    endfunction

    // Adds half an LSB of the result, shifts right by frac (arithmetic) and
    // clamps to a signed out_w-bit range; sat reports whether clamping happened.
    function automatic logic signed [RS_W-1:0] round_sat(
        input  logic signed [RS_W-1:0] acc,
        input  int                     frac,
        input  int                     out_w,
        output logic                   sat
    );
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] half;
        logic signed [RS_W-1:0] rnd;
        logic signed [RS_W-1:0] top;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        one  = {{(RS_W-1){1'b0}}, 1'b1};
        half = (frac > 0) ? (one <<< (frac - 1)) : '0;
        rnd  = (acc + half) >>> frac;
        top  = one <<< (out_w - 1);
        hi   = top - one;
        lo   = -top;
        sat  = 1'b0;
        if (rnd > hi) begin
            rnd = hi;
            sat = 1'b1;
        end else if (rnd < lo) begin
            rnd = lo;
            sat = 1'b1;
        end
        return rnd;
    endfunction

endpackage

// File: rtl/eq_biquad_cascade_if.sv
// -----------------------------------------------------------------------------
// eq_biquad_cascade_if
// Sample stream, coefficient load bus and result signals of the equaliser.
//   Sample in   : i_valid, i_data, i_enable  -> o_ready
//   Coef load   : i_coef_we, i_coef_band, i_coef_idx, i_coef_data, i_coef_commit
//   Result      : o_data, o_valid, o_sat (+ o_sat_cnt when EQ_SAT_CNT_EN is defined)
// Modports: master (sample source / coefficient host), slave (engine).
// -----------------------------------------------------------------------------
interface eq_biquad_cascade_if #(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 32,
    parameter int N_BANDS = 4
);
    localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;

    logic                     i_valid;
    logic signed [DATA_W-1:0] i_data;
    logic                     i_enable;
    logic                     o_ready;
    logic                     i_coef_we;
    logic [BAND_W-1:0]        i_coef_band;
    logic [2:0]               i_coef_idx;
    logic signed [COEF_W-1:0] i_coef_data;
    logic                     i_coef_commit;
    logic signed [DATA_W-1:0] o_data;
    logic                     o_valid;
    logic                     o_sat;
`ifdef EQ_SAT_CNT_EN
    logic [15:0]              o_sat_cnt;
`endif

    modport master (
`ifdef EQ_SAT_CNT_EN
        input  o_sat_cnt,
`endif
        output i_valid, i_data, i_enable,
        output i_coef_we, i_coef_band, i_coef_idx, i_coef_data, i_coef_commit,
        input  o_ready, o_data, o_valid, o_sat
    );

    modport slave (
`ifdef EQ_SAT_CNT_EN
        output o_sat_cnt,
`endif
        input  i_valid, i_data, i_enable,
        input  i_coef_we, i_coef_band, i_coef_idx, i_coef_data, i_coef_commit,
        output o_ready, o_data, o_valid, o_sat
    );

endinterface

// File: rtl/eq_mac.sv
// -----------------------------------------------------------------------------
// eq_mac
// Registered multiply-accumulate shared by all biquad bands.
// Ports:
//   i_clk        : clock
//   i_en         : update the accumulator this cycle
//   i_clr        : start a new sum (accumulator ignores its old value)
//   i_sub        : subtract the product instead of adding it (feedback terms)
//   i_x, i_c     : signed sample and coefficient operands
//   o_y          : accumulator rounded, shifted by COEF_FRAC and saturated
//   o_sat        : o_y was clamped
// The accumulator is pure datapath and carries no reset; every sum starts
// with i_clr. ACC_W must stay below eq_pkg::RS_W.
// -----------------------------------------------------------------------------
module eq_mac
    import eq_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 28,
    parameter int ACC_W     = 64
) (
    input  logic                     i_clk,
    input  logic                     i_en,
    input  logic                     i_clr,
    input  logic                     i_sub,
    input  logic signed [DATA_W-1:0] i_x,
    input  logic signed [COEF_W-1:0] i_c,
    output logic signed [DATA_W-1:0] o_y,
    output logic                     o_sat
);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] x_ext_p0;
    logic signed [PROD_W-1:0] c_ext_p0;
    logic signed [PROD_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]  term_p0;
    logic signed [ACC_W-1:0]  base_p0;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [RS_W-1:0]   acc_wide_p1;
    logic signed [RS_W-1:0]   y_wide_p1;
    logic                     sat_p1;

    // Stage p0: full-precision product, sign-extended to the accumulator.
    assign x_ext_p0 = {{COEF_W{i_x[DATA_W-1]}}, i_x};
    assign c_ext_p0 = {{DATA_W{i_c[COEF_W-1]}}, i_c};
    assign prod_p0  = x_ext_p0 * c_ext_p0;
    assign term_p0  = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    assign base_p0  = i_clr ? '0 : acc_q;
    assign acc_d    = i_sub ? (base_p0 - term_p0) : (base_p0 + term_p0);

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            acc_q <= acc_d;
        end
    end

    // Stage p1: writeback value derived from the registered accumulator.
    assign acc_wide_p1 = {{(RS_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};

    always_comb begin
        sat_p1    = 1'b0;
        y_wide_p1 = round_sat(acc_wide_p1, COEF_FRAC, DATA_W, sat_p1);
    end

    assign o_y   = y_wide_p1[DATA_W-1:0];
    assign o_sat = sat_p1;

endmodule

// File: rtl/eq_biquad_cascade.sv
// -----------------------------------------------------------------------------
// eq_biquad_cascade
// N_BANDS Direct-Form-I biquads in cascade sharing one MAC (eq_mac). Each band
// takes 5 MAC cycles (b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2) and one writeback
// cycle; the result of the last band is presented for one cycle with o_valid.
// Coefficients are written into a shadow bank and copied to the active bank
// in the first idle cycle after a commit request, i.e. on a sample boundary.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : eq_biquad_cascade_if.slave (sample in, coefficient load,
//                  result out)
// Optional build macro EQ_SAT_CNT_EN: adds bus.o_sat_cnt, a saturating count
// of output samples that reported o_sat.
// -----------------------------------------------------------------------------
module eq_biquad_cascade
    import eq_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 32,
    parameter int COEF_FRAC = 28,
    parameter int N_BANDS   = 4,
    parameter int ACC_W     = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    eq_biquad_cascade_if.slave bus
);
    localparam int                BAND_W    = (N_BANDS > 1) ? $clog2(N_BANDS) : 1;
    localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(N_BANDS - 1);
    localparam logic [2:0]        LAST_K    = 3'(N_COEF - 1);

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [DATA_W-1:0] samp_t;

    coef_t     ident    [N_COEF];
    coef_t     shadow_q [N_BANDS][N_COEF];
    coef_t     shadow_d [N_BANDS][N_COEF];
    coef_t     active_q [N_BANDS][N_COEF];
    samp_t     x1_q     [N_BANDS];
    samp_t     x2_q     [N_BANDS];
    samp_t     y1_q     [N_BANDS];
    samp_t     y2_q     [N_BANDS];

    eq_state_e         state_q, state_d;
    logic [BAND_W-1:0] band_q;
    logic [2:0]        k_q;
    samp_t             cur_x_q;
    logic              sat_acc_q;
    logic              pending_q;
    samp_t             o_data_q;
    logic              o_valid_q;
    logic              o_sat_q;
    logic              accept;
    logic              copy_en;

    samp_t             mac_x;
    coef_t             mac_c;
    logic              mac_sub;
    logic              mac_clr;
    logic              mac_en;
    samp_t             mac_y;
    logic              mac_sat;

    for (genvar j = 0; j < N_COEF; j++) begin : g_ident
        localparam logic signed [63:0] IDV = coef_identity(j, COEF_FRAC);
        assign ident[j] = IDV[COEF_W-1:0];
    end

    assign accept  = (state_q == ST_IDLE) && bus.i_valid;
    // A commit seen in an idle cycle is applied before a sample accepted in
    // the same cycle starts its MAC sequence.
    assign copy_en = (state_q == ST_IDLE) && (pending_q || bus.i_coef_commit);

    // Shadow bank including this cycle's write, so a same-cycle commit copies it.
    always_comb begin
        shadow_d = shadow_q;
        if (bus.i_coef_we && (bus.i_coef_idx < 3'(N_COEF)) &&
            (int'(bus.i_coef_band) < N_BANDS)) begin
            shadow_d[bus.i_coef_band][bus.i_coef_idx] = bus.i_coef_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && bus.i_enable) state_d = ST_MAC;
            ST_MAC:  if (k_q == LAST_K) state_d = ST_WB;
            ST_WB:   state_d = (band_q == LAST_BAND) ? ST_OUT : ST_MAC;
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand select for MAC step k of the current band.
    always_comb begin
        mac_x   = cur_x_q;
        mac_c   = active_q[band_q][k_q];
        mac_sub = (k_q >= COEF_A1);
        mac_clr = (k_q == COEF_B0);
        mac_en  = (state_q == ST_MAC);
        case (coef_idx_e'(k_q))
            COEF_B1: mac_x = x1_q[band_q];
            COEF_B2: mac_x = x2_q[band_q];
            COEF_A1: mac_x = y1_q[band_q];
            COEF_A2: mac_x = y2_q[band_q];
            default: mac_x = cur_x_q;
        endcase
    end

    eq_mac #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .ACC_W    (ACC_W)
    ) u_mac (
        .i_clk (i_clk),
        .i_en  (mac_en),
        .i_clr (mac_clr),
        .i_sub (mac_sub),
        .i_x   (mac_x),
        .i_c   (mac_c),
        .o_y   (mac_y),
        .o_sat (mac_sat)
    );

`ifdef EQ_SAT_CNT_EN
    logic [15:0] sat_cnt_q;
    assign bus.o_sat_cnt = sat_cnt_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= 1'b0;
            band_q    <= '0;
            k_q       <= '0;
            sat_acc_q <= 1'b0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_sat_q   <= 1'b0;
`ifdef EQ_SAT_CNT_EN
            sat_cnt_q <= '0;
`endif
            for (int b = 0; b < N_BANDS; b++) begin
                x1_q[b] <= '0;
                x2_q[b] <= '0;
                y1_q[b] <= '0;
                y2_q[b] <= '0;
                for (int c = 0; c < N_COEF; c++) begin
                    shadow_q[b][c] <= ident[c];
                    active_q[b][c] <= ident[c];
                end
            end
        end else begin
            o_valid_q <= 1'b0;
            shadow_q  <= shadow_d;
            if (copy_en) begin
                active_q <= shadow_d;
            end
            pending_q <= copy_en ? 1'b0 : (pending_q | bus.i_coef_commit);

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        band_q    <= '0;
                        k_q       <= '0;
                        sat_acc_q <= 1'b0;
                        if (!bus.i_enable) begin
                            // Bypass: pass the sample straight through and
                            // flush history so re-enabling starts clean.
                            o_data_q  <= bus.i_data;
                            o_sat_q   <= 1'b0;
                            o_valid_q <= 1'b1;
                            for (int b = 0; b < N_BANDS; b++) begin
                                x1_q[b] <= '0;
                                x2_q[b] <= '0;
                                y1_q[b] <= '0;
                                y2_q[b] <= '0;
                            end
                        end
                    end
                end
                ST_MAC: begin
                    k_q <= (k_q == LAST_K) ? '0 : (k_q + 3'd1);
                end
                ST_WB: begin
                    x2_q[band_q] <= x1_q[band_q];
                    x1_q[band_q] <= cur_x_q;
                    y2_q[band_q] <= y1_q[band_q];
                    y1_q[band_q] <= mac_y;
                    sat_acc_q    <= sat_acc_q | mac_sat;
                    if (band_q == LAST_BAND) begin
                        o_data_q  <= mac_y;
                        o_sat_q   <= sat_acc_q | mac_sat;
                        o_valid_q <= 1'b1;
`ifdef EQ_SAT_CNT_EN
                        if ((sat_acc_q | mac_sat) && (sat_cnt_q != 16'hFFFF)) begin
                            sat_cnt_q <= sat_cnt_q + 16'd1;
                        end
`endif
                    end else begin
                        band_q <= band_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Current band input: the accepted sample, then each band's saturated output.
    always_ff @(posedge i_clk) begin
        if (accept && bus.i_enable) begin
            cur_x_q <= bus.i_data;
        end else if (state_q == ST_WB) begin
            cur_x_q <= mac_y;
        end
    end

    assign bus.o_ready = (state_q == ST_IDLE);
    assign bus.o_data  = o_data_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_sat   = o_sat_q;

endmodule

// File: doc/eq_biquad_cascade.md
Name: eq_biquad_cascade

Overview:
- Parametrised multi-band equaliser engine: N_BANDS Direct-Form-I biquads in cascade, all sharing one time-multiplexed multiplier-accumulator.
- Sits in the audio effect chain between the codec sample stream and the downstream effects.
- Coefficients are runtime-loadable through a shadow bank, committed atomically at sample boundaries.
- Successor of the fixed bass/treble LUT EQ: adds arbitrary band count, runtime coefficients and saturation reporting.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 32: coefficient width, signed.
- COEF_FRAC, 28: coefficient fractional bits. Default format is Q4.28.
- N_BANDS, 4: number of cascaded biquads, 1..8.
- ACC_W, 64: accumulator width. Must be at least DATA_W+COEF_W+3.

Ports:
- i_clk, in, 1: sole clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_valid, in, 1: input sample strobe. Accepted only when o_ready=1.
- i_data, in, DATA_W: input sample.
- i_enable, in, 1: 1 = filter, 0 = bypass. Sampled on acceptance.
- o_ready, out, 1: engine idle, can accept a sample.
- i_coef_we, in, 1: write one shadow coefficient.
- i_coef_band, in, $clog2(N_BANDS) (min 1): target band.
- i_coef_idx, in, 3: coefficient select. 0=b0, 1=b1, 2=b2, 3=a1, 4=a2. Values 5..7 are ignored.
- i_coef_data, in, COEF_W: coefficient value.
- i_coef_commit, in, 1: request copy of shadow bank to active bank.
- o_data, out, DATA_W: output sample.
- o_valid, out, 1: one-cycle strobe marking o_data.
- o_sat, out, 1: set with o_valid when any band saturated on that sample.

Behaviour:
- Difference equation per band: y = b0·x + b1·x1 + b2·x2 − a1·y1 − a2·y2.
  - Products are full-precision and accumulated in ACC_W.
  - Writeback: add 2^(COEF_FRAC−1), arithmetic shift right by COEF_FRAC, saturate to DATA_W.
  - Saturated y feeds the next band and is stored as that band's y1.
- FSM states:
  - IDLE → MAC on accepted i_valid with i_enable=1.
  - MAC: 5 cycles, k=0..4, one product per cycle.
  - WB: 1 cycle. Shifts x2←x1, x1←x, y2←y1, y1←y for the current band.
  - From WB: next band → MAC; after band N_BANDS−1 → OUT.
  - OUT → IDLE, with o_valid=1 for that one cycle.
- Latency: accept-to-o_valid = 6·N_BANDS+1 cycles (25 at default).
- o_ready=1 only in IDLE. i_valid while o_ready=0 is dropped with no side effect.
- Bypass (i_enable=0 at acceptance):
  - o_data=i_data and o_valid=1 on the next cycle; o_sat=0.
  - All band states are zeroed, so no transient appears on re-enable.
- Coefficient load:
  - i_coef_we writes the shadow bank any cycle, including while busy.
  - i_coef_commit sets a pending flag. The copy shadow→active happens in the first IDLE cycle with the flag set, which is also the sample boundary; the flag then clears.
  - A sample already in flight always finishes with the old coefficients.
  - Commit and i_valid in the same IDLE cycle: commit applies first, and the new sample uses the new bank.
  - Same-cycle we+commit: the written value is included in the copy.
- o_sat: OR of all writeback saturations for the sample, valid only with o_valid.
- Reset effects (any cycle, including mid-sample):
  - FSM → IDLE.
  - o_valid=0, o_sat=0, o_data=0, o_ready=1 on the following cycle.
  - Band states zeroed.
  - Active and shadow banks set to identity: b0=2^COEF_FRAC, all others 0.
  - Pending commit cleared.
  - An in-flight sample is discarded.
- o_data holds its last value between strobes.

Optional Feature:
- Macro: EQ_SAT_CNT_EN.
- Defined: adds output port o_sat_cnt [15:0]. It increments on each o_valid with o_sat=1, saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent; o_sat behaviour is unchanged.

Decomposition:
- Package eq_pkg holds:
  - coefficient-index enum (COEF_B0..COEF_A2), FSM state enum, N_COEF=5;
  - the identity-coefficient constant function;
  - a saturate/round function parameterised by widths.
- One sub-module, eq_mac: registered multiply-accumulate with clear, load and round/saturate outputs. The controller, state storage and coefficient banks stay in eq_biquad_cascade.

Test Plan:
- Reset, no coefficient load, i_data=1000 → o_data=1000 exactly 25 cycles later, o_sat=0.
- Band0 b0=134217728 (0.5), commit, i_data=−2000 → o_data=−1000.
- Band0 b0=2^30 (4.0), commit, i_data=20000 → o_data=32767, o_sat=1; o_sat_cnt=1 when EQ_SAT_CNT_EN is defined.
- Band0 b0=2^28, a1=−134217728 (pole 0.5), impulse 16384 then zeros → outputs 16384, 8192, 4096, 2048.
- Write b0=0.5 and commit mid-sample → the in-flight sample is unscaled; the next sample is halved. i_valid while busy → no extra o_valid.
- i_enable=0, i_data=−7 → o_data=−7 one cycle later. Assert i_rst during MAC → no o_valid, o_ready=1 next cycle, and the next sample sees identity coefficients.
